// File: rtl/mon_pkg.sv
// Shared types and standard pass signatures for the data-memory write monitor.
package mon_pkg;

   typedef enum logic [1:0] {RUN, DRAIN, PASS, FAIL} mon_state_t;

   typedef struct packed {
      logic [63:0] addr;
      logic [63:0] data;
   } mon_sig_t;

   localparam mon_sig_t SIG_STANDARD2 = '{addr: 64'd100, data: 64'd7};
   localparam mon_sig_t SIG_POWER2    = '{addr: 64'd508, data: 64'd7};
   localparam mon_sig_t SIG_LOADSTORE = '{addr: 64'd80,  data: 64'd1};
   localparam mon_sig_t SIG_MORE      = '{addr: 64'd64,  data: 64'd4950};

   localparam int unsigned DEF_TIMEOUT = 1300;

endpackage

// File: rtl/mem_write_monitor_if.sv
// Snooped CPU data-memory write port: store strobe, address and data.
interface mem_write_monitor_if #(
   parameter int unsigned AW  = 64,
   parameter int unsigned DW  = 64,
   parameter int unsigned MWW = 2
) ();
   import mon_pkg::*;

   logic [MWW-1:0] memwrite;
   logic [AW-1:0]  dataadr;
   logic [DW-1:0]  writedata;

   modport master (output memwrite, output dataadr, output writedata);
   modport slave  (input memwrite, input dataadr, input writedata);
endinterface

// File: rtl/sig_matcher.sv
// Parallel compare of the store against all signature slots; lowest matching slot wins.
module sig_matcher #(
   parameter int unsigned AW   = 64,
   parameter int unsigned DW   = 64,
   parameter int unsigned NSIG = 4
) (
   input  logic [AW-1:0]      dataadr,
   input  logic [DW-1:0]      writedata,
   input  logic [NSIG*AW-1:0] sig_addr,
   input  logic [NSIG*DW-1:0] sig_data,
   input  logic [NSIG-1:0]    sig_en,
   output logic               hit,
   output logic [3:0]         idx
);
   import mon_pkg::*;

   // Descending scan so the lowest index is written last; an unknown compare is not taken.
   always_comb begin
      hit = 1'b0;
      idx = 4'd0;
      for (int i = int'(NSIG) - 1; i >= 0; i--) begin
         if (sig_en[i] && (dataadr == sig_addr[i*AW +: AW])
             && (writedata == sig_data[i*DW +: DW])) begin
            hit = 1'b1;
            idx = 4'(i);
         end
      end
   end

endmodule

// File: rtl/mem_write_monitor.sv
// End-of-test monitor: matches stores against pass signatures, runs a watchdog and drain.
// Optional MONITOR_TRACE_EN adds simulation-only store and verdict trace lines.
module mem_write_monitor #(
   parameter int unsigned AW      = 64,
   parameter int unsigned DW      = 64,
   parameter int unsigned MWW     = 2,
   parameter int unsigned NSIG    = 4,
   parameter int unsigned TIMEOUT = mon_pkg::DEF_TIMEOUT,
   parameter int unsigned DRAIN   = 10
) (
   input  logic               clk,
   input  logic               reset,
   mem_write_monitor_if.slave bus,
   input  logic [NSIG*AW-1:0] sig_addr,
   input  logic [NSIG*DW-1:0] sig_data,
   input  logic [NSIG-1:0]    sig_en,
   output logic               pass,
   output logic               fail,
   output logic               done,
   output logic [3:0]         hit_idx,
   output logic [31:0]        wr_count,
   output logic [31:0]        cyc_count
);
   import mon_pkg::*;

   mon_state_t  state_q, state_d;
   logic [31:0] cyc_q, cyc_d;
   logic [31:0] wr_q, wr_d;
   logic [31:0] drain_q, drain_d;
   logic [3:0]  idx_q, idx_d;
   logic        pass_q, fail_q, done_q;
   logic        store, hit;
   logic [3:0]  match_idx;

   assign store = |bus.memwrite;

   sig_matcher #(
      .AW   (AW),
      .DW   (DW),
      .NSIG (NSIG)
   ) u_sig_matcher (
      .dataadr   (bus.dataadr),
      .writedata (bus.writedata),
      .sig_addr  (sig_addr),
      .sig_data  (sig_data),
      .sig_en    (sig_en),
      .hit       (hit),
      .idx       (match_idx)
   );

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      wr_d    = wr_q;
      drain_d = drain_q;
      idx_d   = idx_q;

      if (store && (state_q == mon_pkg::RUN || state_q == mon_pkg::DRAIN) && wr_q != '1) begin
         wr_d = wr_q + 32'd1;
      end

      unique case (state_q)
         mon_pkg::RUN: begin
            cyc_d = cyc_q + 32'd1;
            // A match on the watchdog edge still takes the pass path.
            if (store && hit) begin
               idx_d   = match_idx;
               drain_d = 32'd0;
               state_d = (DRAIN == 0) ? mon_pkg::PASS : mon_pkg::DRAIN;
            end else if (cyc_q + 32'd1 == TIMEOUT) begin
               state_d = mon_pkg::FAIL;
            end
         end
         mon_pkg::DRAIN: begin
            if (drain_q + 32'd1 == DRAIN) begin
               state_d = mon_pkg::PASS;
            end else begin
               drain_d = drain_q + 32'd1;
            end
         end
         mon_pkg::PASS, mon_pkg::FAIL: begin
         end
         default: state_d = mon_pkg::RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= mon_pkg::RUN;
         cyc_q   <= 32'd0;
         wr_q    <= 32'd0;
         drain_q <= 32'd0;
         idx_q   <= 4'd0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         wr_q    <= wr_d;
         drain_q <= drain_d;
         idx_q   <= idx_d;
         pass_q  <= (state_d == mon_pkg::PASS);
         fail_q  <= (state_d == mon_pkg::FAIL);
         done_q  <= (state_d == mon_pkg::PASS) || (state_d == mon_pkg::FAIL);
      end
   end

   assign pass      = pass_q;
   assign fail      = fail_q;
   assign done      = done_q;
   assign hit_idx   = idx_q;
   assign wr_count  = wr_q;
   assign cyc_count = cyc_q;

`ifdef MONITOR_TRACE_EN
   always @(posedge clk) begin
      if (!reset) begin
         if (store && (state_q == mon_pkg::RUN || state_q == mon_pkg::DRAIN)) begin
            $display("Write %d in %d", bus.writedata, bus.dataadr);
         end
         if (state_d == mon_pkg::PASS && state_q != mon_pkg::PASS) begin
            $display("Verdict: pass, hit_idx %0d", idx_d);
         end
         if (state_d == mon_pkg::FAIL && state_q != mon_pkg::FAIL) begin
            $display("Verdict: watchdog expired, cyc_count %0d", cyc_d);
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed bench for mem_write_monitor: DRAIN=10 instance plus a DRAIN=0 instance on one bus.
module tb_mem_write_monitor;
   import mon_pkg::*;

   localparam int unsigned AW   = 64;
   localparam int unsigned DW   = 64;
   localparam int unsigned NSIG = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic [NSIG*AW-1:0] sig_addr;
   logic [NSIG*DW-1:0] sig_data;
   logic [NSIG-1:0]    sig_en;

   logic        pass, fail, done;
   logic [3:0]  hit_idx;
   logic [31:0] wr_count, cyc_count;
   logic        pass0, fail0, done0;
   logic [3:0]  hit_idx0;
   logic [31:0] wr_count0, cyc_count0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_write_monitor_if #(.AW(AW), .DW(DW), .MWW(2)) bus ();

   mem_write_monitor #(
      .AW(AW), .DW(DW), .MWW(2), .NSIG(NSIG), .TIMEOUT(1300), .DRAIN(10)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .sig_addr(sig_addr), .sig_data(sig_data), .sig_en(sig_en),
      .pass(pass), .fail(fail), .done(done), .hit_idx(hit_idx),
      .wr_count(wr_count), .cyc_count(cyc_count)
   );

   mem_write_monitor #(
      .AW(AW), .DW(DW), .MWW(2), .NSIG(NSIG), .TIMEOUT(1300), .DRAIN(0)
   ) dut0 (
      .clk(clk), .reset(reset), .bus(bus),
      .sig_addr(sig_addr), .sig_data(sig_data), .sig_en(sig_en),
      .pass(pass0), .fail(fail0), .done(done0), .hit_idx(hit_idx0),
      .wr_count(wr_count0), .cyc_count(cyc_count0)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic std_sigs();
      sig_addr[0*AW +: AW] = SIG_STANDARD2.addr;  sig_data[0*DW +: DW] = SIG_STANDARD2.data;
      sig_addr[1*AW +: AW] = SIG_POWER2.addr;     sig_data[1*DW +: DW] = SIG_POWER2.data;
      sig_addr[2*AW +: AW] = SIG_LOADSTORE.addr;  sig_data[2*DW +: DW] = SIG_LOADSTORE.data;
      sig_addr[3*AW +: AW] = SIG_MORE.addr;       sig_data[3*DW +: DW] = SIG_MORE.data;
      sig_en = 4'hF;
   endtask

   task automatic do_reset();
      bus.memwrite = 2'b00;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
   endtask

   task automatic store(input logic [63:0] a, input logic [63:0] d);
      bus.memwrite  = 2'b01;
      bus.dataadr   = a;
      bus.writedata = d;
      tick(1);
      bus.memwrite  = 2'b00;
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".pass"}, 64'(pass), 64'd0);
      check({tag, ".fail"}, 64'(fail), 64'd0);
      check({tag, ".done"}, 64'(done), 64'd0);
      check({tag, ".hit_idx"}, 64'(hit_idx), 64'd0);
      check({tag, ".wr_count"}, 64'(wr_count), 64'd0);
      check({tag, ".cyc_count"}, 64'(cyc_count), 64'd0);
   endtask

   // Store 100/7 on the 30th run edge, pass must rise exactly 10 edges later.
   task automatic run_pass30(input string tag);
      tick(29);
      store(64'd100, 64'd7);
      check({tag, ".cyc_at_hit"}, 64'(cyc_count), 64'd30);
      check({tag, ".wr_at_hit"}, 64'(wr_count), 64'd1);
      tick(9);
      check({tag, ".pass_early"}, 64'(pass), 64'd0);
      tick(1);
      check({tag, ".pass"}, 64'(pass), 64'd1);
      check({tag, ".done"}, 64'(done), 64'd1);
      check({tag, ".fail"}, 64'(fail), 64'd0);
      check({tag, ".hit_idx"}, 64'(hit_idx), 64'd0);
      check({tag, ".cyc_frozen"}, 64'(cyc_count), 64'd30);
   endtask

   initial begin
      bus.memwrite  = 2'b00;
      bus.dataadr   = '0;
      bus.writedata = '0;
      sig_addr = '0;
      sig_data = '0;
      std_sigs();

      // 1: reset values, then the basic pass run
      do_reset();
      check_zero("reset");
      run_pass30("s1");
      store(64'd508, 64'd7);
      check("s1.wr_hold_in_pass", 64'(wr_count), 64'd1);

      // 2: watchdog with three non-matching stores
      do_reset();
      store(64'd100, 64'd8);
      store(64'd508, 64'd6);
      store(64'd0, 64'd0);
      tick(1296);
      check("s2.fail_early", 64'(fail), 64'd0);
      tick(1);
      check("s2.fail", 64'(fail), 64'd1);
      check("s2.done", 64'(done), 64'd1);
      check("s2.cyc", 64'(cyc_count), 64'd1300);
      check("s2.pass", 64'(pass), 64'd0);
      check("s2.wr", 64'(wr_count), 64'd3);
      tick(5);
      check("s2.cyc_hold", 64'(cyc_count), 64'd1300);

      // 3a: duplicate signature in slot 3, lowest slot wins
      sig_addr[3*AW +: AW] = 64'd508;
      sig_data[3*DW +: DW] = 64'd7;
      do_reset();
      store(64'd508, 64'd7);
      check("s3.dup_idx", 64'(hit_idx), 64'd1);
      check("s3.dup_idx0", 64'(hit_idx0), 64'd1);
      std_sigs();

      // 3b: match on the watchdog edge
      do_reset();
      tick(1299);
      check("s3.cyc_before", 64'(cyc_count), 64'd1299);
      store(64'd80, 64'd1);
      check("s3.tie_fail", 64'(fail), 64'd0);
      check("s3.tie_idx", 64'(hit_idx), 64'd2);
      tick(10);
      check("s3.tie_pass", 64'(pass), 64'd1);
      check("s3.tie_fail_late", 64'(fail), 64'd0);

      // 4: DRAIN=0 passes on the store edge; stores during DRAIN do not rematch
      do_reset();
      store(64'd64, 64'd4950);
      check("s4.d0_pass", 64'(pass0), 64'd1);
      check("s4.d0_idx", 64'(hit_idx0), 64'd3);
      check("s4.pass", 64'(pass), 64'd0);
      tick(2);
      store(64'd100, 64'd7);
      check("s4.drain_idx", 64'(hit_idx), 64'd3);
      check("s4.drain_wr", 64'(wr_count), 64'd2);
      tick(6);
      check("s4.pass_early", 64'(pass), 64'd0);
      tick(1);
      check("s4.pass", 64'(pass), 64'd1);

      // 5: reset during DRAIN and during FAIL
      do_reset();
      store(64'd100, 64'd7);
      tick(3);
      do_reset();
      check_zero("s5.drain_rst");
      run_pass30("s5");
      do_reset();
      tick(1300);
      check("s5.fail", 64'(fail), 64'd1);
      do_reset();
      check_zero("s5.fail_rst");

      // 6: disabled slot and unknown data bits never match
      do_reset();
      sig_en = 4'b1110;
      store(64'd100, 64'd7);
      tick(10);
      check("s6.en_pass", 64'(pass), 64'd0);
      check("s6.en_cyc", 64'(cyc_count), 64'd11);
      check("s6.en_wr", 64'(wr_count), 64'd1);
      sig_en = 4'hF;
      store(64'd100, {60'd0, 4'b1xxx});
      tick(10);
      check("s6.x_pass", 64'(pass), 64'd0);
      check("s6.x_cyc", 64'(cyc_count), 64'd22);
      check("s6.x_wr", 64'(wr_count), 64'd2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
